// File: rtl/temp_result_filter.sv
// rtl/temp_result_filter.sv - block averager, running min/max and hysteretic over-temperature alarm
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   i_res           W-bit unsigned measurement result
//   i_res_valid     one-cycle strobe qualifying i_res
//   i_thr_hi        alarm set threshold (sampled only when a new average is produced)
//   i_clr_minmax    one-cycle strobe re-arming min/max tracking
//   o_avg           last completed block average (2**LOG2_AVG samples, truncated)
//   o_avg_valid     one-cycle pulse after o_avg updates
//   o_min, o_max    running minimum / maximum since reset or clear
//   o_alarm         over-temperature flag with HYST LSBs of hysteresis

module temp_result_filter #(
    parameter int W        = 7,
    parameter int LOG2_AVG = 2,
    parameter int HYST     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_res,
    input  logic         i_res_valid,
    input  logic [W-1:0] i_thr_hi,
    input  logic         i_clr_minmax,
    output logic [W-1:0] o_avg,
    output logic         o_avg_valid,
    output logic [W-1:0] o_min,
    output logic [W-1:0] o_max,
    output logic         o_alarm
);

    // Accumulator holds N samples of W bits, so W+LOG2_AVG bits never overflow.
    localparam int AW = W + LOG2_AVG;
    // Counter needs at least one bit so LOG2_AVG = 0 still elaborates; it then stays at 0.
    localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);
    localparam logic [W-1:0]  HYST_W   = W'(HYST);

    // DUMP marks the cycle right after a block completed; it drives o_avg_valid.
    // Both states accept samples, so back-to-back strobes are never dropped.
    typedef enum logic {ACCUM = 1'b0, DUMP = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   acc, acc_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [W-1:0]    avg_nxt, min_nxt, max_nxt;
    logic            alarm_nxt;
    logic [AW-1:0]   sum;
    logic [W-1:0]    avg_new;
    logic [W-1:0]    thr_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            o_avg   <= '0;
            o_min   <= '1;
            o_max   <= '0;
            o_alarm <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            o_avg   <= avg_nxt;
            o_min   <= min_nxt;
            o_max   <= max_nxt;
            o_alarm <= alarm_nxt;
        end
    end

    assign o_avg_valid = (state == DUMP);

    always_comb begin
        state_nxt = ACCUM;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        avg_nxt   = o_avg;
        alarm_nxt = o_alarm;
        min_nxt   = o_min;
        max_nxt   = o_max;

        sum     = acc + AW'(i_res);
        avg_new = W'(sum >> LOG2_AVG);
        // Clear threshold saturates at 0; a zero clear threshold means the alarm latches.
        thr_lo  = (i_thr_hi >= HYST_W) ? (i_thr_hi - HYST_W) : '0;

        if (i_res_valid) begin
            if (cnt == CNT_LAST) begin
                state_nxt = DUMP;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                avg_nxt   = avg_new;
                if (avg_new >= i_thr_hi) begin
                    alarm_nxt = 1'b1;
                end else if (avg_new < thr_lo) begin
                    alarm_nxt = 1'b0;
                end
            end else begin
                acc_nxt = sum;
                cnt_nxt = cnt + CW'(1);
            end
        end

        // A clear coinciding with a sample seeds tracking with that sample.
        if (i_clr_minmax && i_res_valid) begin
            min_nxt = i_res;
            max_nxt = i_res;
        end else if (i_clr_minmax) begin
            min_nxt = '1;
            max_nxt = '0;
        end else if (i_res_valid) begin
            if (i_res < o_min) min_nxt = i_res;
            if (i_res > o_max) max_nxt = i_res;
        end
    end

endmodule
